// File: rtl/pla_sweep_ctrl.sv
// Sweeps a single-output combinational function over an inclusive input range,
// counting onset vectors and recording the lowest one.
module pla_sweep_ctrl #(
    parameter int IN_W  = 16,
    parameter int CNT_W = IN_W + 1,
    parameter int LAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IN_W-1:0]  req_start,
    input  logic [IN_W-1:0]  req_end,
    output logic [IN_W-1:0]  func_x,
    output logic             func_x_valid,
    input  logic             func_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_count,
    output logic             res_hit,
    output logic [IN_W-1:0]  res_first,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

    state_t            state, state_nxt;
    logic [DW-1:0]     drain_cnt;
    logic [IN_W-1:0]   end_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              hit_q;
    logic [IN_W-1:0]   first_q;
    logic              accept;
    logic              last_vec;
    logic              smp_vld;
    logic [IN_W-1:0]   smp_x;

    assign accept   = req_valid & req_ready;
    // Termination is decided before incrementing so end=all-ones never wraps.
    assign last_vec = (func_x == end_q);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (req_start <= req_end) ? SWEEP : DONE;
            SWEEP:   if (last_vec) state_nxt = (LAT > 0) ? DRAIN : DONE;
            DRAIN:   if (drain_cnt == '0) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready    = (state == IDLE);
        func_x_valid = (state == SWEEP);
        res_valid    = (state == DONE);
        busy         = (state != IDLE);
    end

    // Tags travel alongside the function latency so each func_y lines up with its vector.
    generate
        if (LAT == 0) begin : g_nolat
            assign smp_vld = func_x_valid;
            assign smp_x   = func_x;
        end else begin : g_lat
            logic [LAT-1:0]  tag_vld_p;
            logic [IN_W-1:0] tag_x_p [LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    tag_vld_p <= '0;
                end else begin
                    tag_vld_p[0] <= func_x_valid;
                    for (int i = 1; i < LAT; i++) tag_vld_p[i] <= tag_vld_p[i-1];
                end
            end

            always_ff @(posedge clk) begin
                tag_x_p[0] <= func_x;
                for (int i = 1; i < LAT; i++) tag_x_p[i] <= tag_x_p[i-1];
            end

            assign smp_vld = tag_vld_p[LAT-1];
            assign smp_x   = tag_x_p[LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            func_x    <= '0;
            end_q     <= '0;
            cnt_q     <= '0;
            hit_q     <= 1'b0;
            first_q   <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == IDLE && accept) begin
                end_q   <= req_end;
                cnt_q   <= '0;
                hit_q   <= 1'b0;
                first_q <= '0;
                if (req_start <= req_end) func_x <= req_start;
            end else begin
                if (state == SWEEP && !last_vec) func_x <= func_x + 1'b1;
                if (smp_vld && func_y) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!hit_q) begin
                        hit_q   <= 1'b1;
                        first_q <= smp_x;
                    end
                end
            end
            if (state == SWEEP)
                drain_cnt <= DW'(LAT - 1);
            else if (state == DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - 1'b1;
        end
    end

    assign res_count = cnt_q;
    assign res_hit   = hit_q;
    assign res_first = first_q;

endmodule

// File: tb/tb_pla_sweep_ctrl.sv
// Bench for pla_sweep_ctrl: a LAT=0 and a LAT=2 instance share the request side
// and are checked every cycle against a range-level model plus literal expectations.
module tb_pla_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        res_ready = 1'b1;
    logic [15:0] req_start = '0;
    logic [15:0] req_end = '0;
    int          fsel = 0;
    int          cyc = 0;

    logic        rr0, fxv0, rv0, rh0, bz0, fy0;
    logic [15:0] fx0, rf0;
    logic [16:0] rc0;
    logic        rr2, fxv2, rv2, rh2, bz2, fy2;
    logic [15:0] fx2, rf2;
    logic [16:0] rc2;
    logic        y2_r1, y2_r2;

    int n_chk = 0;
    int n_fail = 0;
    int vcnt0 = 0;
    int rvcnt = 0;

    int          m_act [2], m_T [2], m_N [2], m_done [2], m_cnt [2];
    bit          m_hit [2], m_zero [2], m_empty [2];
    logic [15:0] m_s [2], m_fx [2], m_first [2];

    function automatic logic fmodel(input int d, input int fs, input logic [15:0] x);
        if (d == 1) return (x == 16'h000A);
        case (fs)
            0:       return x[0] & x[1];
            1:       return 1'b1;
            default: return x[3] ^ x[7];
        endcase
    endfunction

    assign fy0 = fmodel(0, fsel, fx0);
    assign fy2 = y2_r2;

    always @(posedge clk) begin
        y2_r1 <= (fx2 == 16'h000A);
        y2_r2 <= y2_r1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial forever #5 clk = ~clk;

    pla_sweep_ctrl #(.IN_W(16), .CNT_W(17), .LAT(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr0),
        .req_start(req_start), .req_end(req_end), .func_x(fx0), .func_x_valid(fxv0),
        .func_y(fy0), .res_valid(rv0), .res_ready(res_ready), .res_count(rc0),
        .res_hit(rh0), .res_first(rf0), .busy(bz0)
    );

    pla_sweep_ctrl #(.IN_W(16), .CNT_W(17), .LAT(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr2),
        .req_start(req_start), .req_end(req_end), .func_x(fx2), .func_x_valid(fxv2),
        .func_y(fy2), .res_valid(rv2), .res_ready(res_ready), .res_count(rc2),
        .res_hit(rh2), .res_first(rf2), .busy(bz2)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon_dut(input int d, input string p, input logic rr, input logic [15:0] fx,
                           input logic fxv, input logic rv, input logic [16:0] rc,
                           input logic rh, input logic [15:0] rf, input logic bz);
        bit sweep, rve;
        sweep = m_act[d] != 0 && !m_empty[d] && cyc >= m_T[d] + 1 && cyc <= m_T[d] + m_N[d];
        rve   = m_act[d] != 0 && cyc >= m_done[d];
        chk({p, ".req_ready"}, rr, m_act[d] == 0);
        chk({p, ".busy"}, bz, m_act[d] != 0);
        chk({p, ".func_x_valid"}, fxv, sweep);
        chk({p, ".func_x"}, fx, m_fx[d]);
        chk({p, ".res_valid"}, rv, rve);
        if (rve) begin
            chk({p, ".res_count"}, rc, m_cnt[d]);
            chk({p, ".res_hit"}, rh, m_hit[d]);
            chk({p, ".res_first"}, rf, m_first[d]);
        end else if (m_zero[d]) begin
            chk({p, ".res_count_rst"}, rc, 0);
            chk({p, ".res_hit_rst"}, rh, 0);
            chk({p, ".res_first_rst"}, rf, 0);
        end
    endtask

    // Advance the model across the coming edge using the inputs held this cycle.
    task automatic adv(input int d, input int lat);
        if (rst) begin
            m_act[d] = 0; m_fx[d] = '0; m_zero[d] = 1'b1;
        end else if (m_act[d] == 0 && req_valid) begin
            m_act[d] = 1; m_zero[d] = 1'b0; m_T[d] = cyc; m_s[d] = req_start;
            m_empty[d] = (req_start > req_end);
            m_cnt[d] = 0; m_hit[d] = 1'b0; m_first[d] = '0;
            if (!m_empty[d]) begin
                m_N[d] = int'(req_end) - int'(req_start) + 1;
                for (int v = int'(req_start); v <= int'(req_end); v++) begin
                    if (fmodel(d, fsel, 16'(v))) begin
                        m_cnt[d]++;
                        if (!m_hit[d]) begin m_hit[d] = 1'b1; m_first[d] = 16'(v); end
                    end
                end
                m_fx[d] = req_start;
                m_done[d] = cyc + 1 + m_N[d] + lat;
            end else begin
                m_N[d] = 0;
                m_done[d] = cyc + 1;
            end
        end else if (m_act[d] != 0) begin
            if (cyc >= m_done[d] && res_ready) m_act[d] = 0;
            else if (!m_empty[d] && cyc + 1 <= m_T[d] + m_N[d]) m_fx[d] = m_s[d] + 16'(cyc - m_T[d]);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rr0 && rr2) begin ok = 1'b1; break; end
        end
        chk("idle_timeout", ok, 1);
    endtask

    task automatic send(input logic [15:0] s, input logic [15:0] e, output int t);
        wait_idle();
        @(posedge clk); #1;
        req_start = s; req_end = e; req_valid = 1'b1;
        @(negedge clk); t = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    int lat0, lat2, T, vb;
    logic [16:0] c0, c2;
    logic        h0, h2;
    logic [15:0] f0, f2;

    task automatic wait_res(input int t, input int lim);
        lat0 = -1; lat2 = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (lat0 < 0 && rv0) begin lat0 = cyc - t; c0 = rc0; h0 = rh0; f0 = rf0; end
            if (lat2 < 0 && rv2) begin lat2 = cyc - t; c2 = rc2; h2 = rh2; f2 = rf2; end
            if (lat0 >= 0 && lat2 >= 0) break;
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 0; m_T[d] = 0; m_N[d] = 0; m_done[d] = 0; m_cnt[d] = 0;
            m_hit[d] = 1'b0; m_zero[d] = 1'b1; m_empty[d] = 1'b0;
            m_s[d] = '0; m_fx[d] = '0; m_first[d] = '0;
        end
        fork
            forever begin
                @(negedge clk);
                if (cyc >= 1) begin
                    mon_dut(0, "d0", rr0, fx0, fxv0, rv0, rc0, rh0, rf0, bz0);
                    mon_dut(1, "d2", rr2, fx2, fxv2, rv2, rc2, rh2, rf2, bz2);
                    if (fxv0) vcnt0++;
                    if (rv0 || rv2) rvcnt++;
                end
                adv(0, 0);
                adv(1, 2);
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst.req_ready", rr0, 1);
        chk("rst.busy", bz0, 0);
        chk("rst.func_x", fx0, 0);
        chk("rst.func_x_valid", fxv0, 0);
        chk("rst.res_valid", rv0, 0);
        chk("rst.res_count", rc0, 0);
        rst = 1'b0;

        fsel = 0;
        send(16'd0, 16'd15, T);
        wait_res(T, 100);
        chk("and2.lat", lat0, 17);
        chk("and2.count", c0, 4);
        chk("and2.hit", h0, 1);
        chk("and2.first", f0, 3);
        chk("eqA.lat", lat2, 19);
        chk("eqA.count", c2, 1);
        chk("eqA.first", f2, 16'h000A);

        fsel = 1;
        send(16'd0, 16'hFFFF, T);
        vb = vcnt0;
        wait_res(T, 70000);
        chk("full.lat", lat0, 65537);
        chk("full.count", c0, 65536);
        chk("full.lat2", lat2, 65539);
        chk("full.count2", c2, 1);
        repeat (5) @(negedge clk);
        chk("full.valid_cycles", vcnt0 - vb, 65536);

        fsel = 0;
        vb = vcnt0;
        send(16'd9, 16'd4, T);
        wait_res(T, 20);
        chk("empty.lat", lat0, 1);
        chk("empty.lat2", lat2, 1);
        chk("empty.count", c0, 0);
        chk("empty.hit", h0, 0);
        chk("empty.first", f0, 0);
        chk("empty.valid_cycles", vcnt0 - vb, 0);

        send(16'd8, 16'd12, T);
        wait_res(T, 40);
        chk("lat2.lat", lat2, 8);
        chk("lat2.count", c2, 1);
        chk("lat2.hit", h2, 1);
        chk("lat2.first", f2, 16'h000A);
        chk("lat2.d0_lat", lat0, 6);
        chk("lat2.d0_first", f0, 11);

        @(posedge clk); #1;
        res_ready = 1'b0;
        send(16'd2, 16'd5, T);
        wait_res(T, 40);
        chk("bp.lat", lat0, 5);
        chk("bp.lat2", lat2, 7);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp.res_valid", rv0, 1);
            chk("bp.req_ready", rr0, 0);
            chk("bp.count", rc0, 1);
            chk("bp.first", rf0, 3);
            chk("bp.req_ready2", rr2, 0);
            chk("bp.count2", rc2, 0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.release_ready", rr0, 1);
        chk("bp.release_valid", rv0, 0);
        chk("bp.release_ready2", rr2, 1);

        send(16'd0, 16'd100, T);
        for (int i = 0; i < 200 && cyc < T + 19; i++) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid.req_ready", rr0, 1);
        chk("mid.busy", bz0, 0);
        chk("mid.func_x", fx0, 0);
        chk("mid.func_x_valid", fxv0, 0);
        chk("mid.res_valid", rv0, 0);
        chk("mid.res_count", rc0, 0);
        chk("mid.res_hit", rh0, 0);
        chk("mid.res_first", rf0, 0);
        chk("mid.func_x2", fx2, 0);
        chk("mid.busy2", bz2, 0);
        vb = rvcnt;
        repeat (150) @(negedge clk);
        chk("mid.no_result", rvcnt - vb, 0);

        send(16'hFFF0, 16'hFFFF, T);
        wait_res(T, 60);
        chk("top.lat", lat0, 17);
        chk("top.count", c0, 4);
        chk("top.first", f0, 16'hFFF3);
        chk("top.lat2", lat2, 19);
        chk("top.count2", c2, 0);
        chk("top.hit2", h2, 0);
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pla_sweep_ctrl.md
Name: pla_sweep_ctrl

Overview:
- Sequencer that drives a single-output combinational PLA-derived function (16 inputs, one output) through a caller-supplied inclusive input range, one vector per cycle.
- Samples the function output, counts onset minterms and records the first onset vector.
- Sits between a host/test harness (request/result handshakes) and one instance of the optimised function netlist, so one function instance is exhaustively or partially characterised in hardware.

Parameters:
- IN_W, 16, function input width; vector bit i drives function input x<i>
- CNT_W, IN_W+1, onset counter width (holds 2^IN_W without overflow)
- LAT, 0, cycles between func_x change and a valid func_y; 0 = purely combinational, sampled same cycle

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  sweep request present
- req_ready  output  1  controller can accept a request
- req_start  input  IN_W  first vector, inclusive
- req_end  input  IN_W  last vector, inclusive
- func_x  output  IN_W  vector driven to the function
- func_x_valid  output  1  func_x is part of the active sweep
- func_y  input  1  function output for the vector driven LAT cycles earlier
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_count  output  CNT_W  number of vectors with func_y=1
- res_hit  output  1  at least one onset vector found
- res_first  output  IN_W  lowest onset vector; 0 when res_hit=0
- busy  output  1  state is not IDLE

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, func_x=0, func_x_valid=0, res_valid=0, res_count=0, res_hit=0, res_first=0, busy=0, LAT pipeline tags cleared. Reset has priority in every state; a sweep in progress is abandoned and no result is produced.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch start/end and clear count/hit/first.
  - If start<=end, go to SWEEP with func_x=start and func_x_valid=1 next cycle.
  - If start>end (empty range), go to DONE with count=0, hit=0.
- SWEEP:
  - One vector per cycle. func_x increments by 1 each cycle.
  - Termination is decided by comparing func_x==end before incrementing. end=all-ones must not wrap to 0 or re-sweep.
  - After the cycle with func_x==end: go to DRAIN if LAT>0, else DONE. func_x_valid drops to 0 and func_x holds its last value.
- Sampling:
  - A LAT-deep shift register carries (valid, vector) tags aligned with func_y.
  - For each valid tag with func_y=1: count+=1; if hit==0, set first=tag vector and hit=1.
  - func_y is ignored when the tag is invalid.
- DRAIN: lasts exactly LAT cycles to retire in-flight tags, then go to DONE.
- DONE:
  - res_valid=1. res_* remain stable until res_valid&res_ready, then go to IDLE.
  - req_ready=0 in all states except IDLE; a request presented during DONE waits.
- Latency: request accepted at edge T, range size N=end-start+1. res_valid rises at cycle T+1+N+LAT. Empty range: res_valid at T+1.
- Arithmetic: count is unsigned CNT_W with no saturation needed; max 2^IN_W fits. Vector compare is unsigned.
- busy=1 in SWEEP, DRAIN and DONE.

Test Plan:
- Bench function y=x0&x1, LAT=0, start=0, end=15 -> res_count=4, res_hit=1, res_first=3, res_valid at T+17.
- Bench function y=1, LAT=0, start=0, end=0xFFFF -> res_count=65536, exactly 65536 func_x_valid cycles, no second pass after 0xFFFF.
- start=9, end=4 -> res_valid at T+1, res_count=0, res_hit=0, res_first=0, func_x_valid never asserted.
- LAT=2, function y=(x==0x0A) registered twice in the bench, start=8, end=12 -> res_count=1, res_first=0x000A, res_valid at T+8.
- Backpressure: res_ready held low 10 cycles after res_valid -> res_* stable and req_ready=0 throughout; completion on the first res_ready=1 cycle, then req_ready=1.
- rst asserted mid-sweep (start=0, end=100, at cycle T+20) -> next cycle all outputs at reset values, no result produced; a new request is accepted normally afterwards.
